// File: rtl/rtc_bus_burst_ctrl_if.sv
// Pad-side signal bundle of the RTC multiplexed address/data bus.
// The master drives the strobes and the output half of the tri-state pad.
interface rtc_bus_burst_ctrl_if #(
   parameter int DATA_W = 8
);
   logic              cs_n;
   logic              ad_n;
   logic              wr_n;
   logic              rd_n;
   logic              bus_oe;
   logic [DATA_W-1:0] bus_out;
   logic [DATA_W-1:0] bus_in;

   modport master (
      output cs_n, ad_n, wr_n, rd_n, bus_oe, bus_out,
      input  bus_in
   );

   modport slave (
      input  cs_n, ad_n, wr_n, rd_n, bus_oe, bus_out,
      output bus_in
   );
endinterface

// File: rtl/rtc_bus_burst_ctrl.sv
// Burst master for the RTC multiplexed address/data bus (address phase, then data phase per register).
// Optional BCD check of read bytes is enabled by defining RTC_BCD_CHECK_EN.
module rtc_bus_burst_ctrl #(
   parameter int  DATA_W = 8,
   parameter int  NREG   = 9,
   parameter int  T_STB  = 4,
   parameter int  T_HLD  = 2,
   parameter int  T_GAP  = 2,
   localparam int CW     = $clog2(NREG + 1)
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   start,
   input  logic                   rw,
   input  logic [DATA_W-1:0]      base_addr,
   input  logic [CW-1:0]          count,
   input  logic [NREG*DATA_W-1:0] wr_data,
   output logic [NREG*DATA_W-1:0] rd_data,
   output logic                   busy,
   output logic                   done,
   output logic [NREG-1:0]        bcd_err,
   rtc_bus_burst_ctrl_if.master   bus
);

   localparam int TMAX = (T_STB > T_HLD) ? ((T_STB > T_GAP) ? T_STB : T_GAP)
                                         : ((T_HLD > T_GAP) ? T_HLD : T_GAP);
   localparam int TW   = (TMAX > 1) ? $clog2(TMAX) : 1;

   typedef enum logic [3:0] {
      S_IDLE, S_A_SET, S_A_STB, S_A_HLD, S_A_GAP,
      S_D_SET, S_D_STB, S_D_HLD, S_D_GAP, S_DONE
   } state_t;

   state_t                   state_r, state_nxt_s;
   logic [TW-1:0]            tmr_r;
   logic [CW-1:0]            k_r, k_nxt_s, cnt_r, cnt_clamp_s;
   logic                     rw_r;
   logic [DATA_W-1:0]        base_r, addr_nxt_s, wbyte_nxt_s;
   logic [NREG*DATA_W-1:0]   wdat_r;
   logic                     accept_s, capture_s;
   logic                     cs_n_nxt_s, ad_n_nxt_s, wr_n_nxt_s, rd_n_nxt_s, oe_nxt_s;
   logic [DATA_W-1:0]        out_nxt_s;
   logic                     cs_n_r, ad_n_r, wr_n_r, rd_n_r, oe_r;
   logic [DATA_W-1:0]        out_r;
   logic                     busy_r, done_r;

   // Timer reload value (cycles minus one) for a state entered next.
   function automatic logic [TW-1:0] dur_m1(input state_t s);
      case (s)
         S_A_STB, S_D_STB: dur_m1 = TW'(T_STB - 1);
         S_A_HLD, S_D_HLD: dur_m1 = TW'(T_HLD - 1);
         S_A_GAP, S_D_GAP: dur_m1 = TW'(T_GAP - 1);
         default:          dur_m1 = TW'(0);
      endcase
   endfunction

   assign accept_s    = start && ((state_r == S_IDLE) || (state_r == S_DONE));
   assign cnt_clamp_s = (count > CW'(NREG)) ? CW'(NREG) : count;
   assign capture_s   = (state_r == S_D_STB) && (tmr_r == TW'(0)) && rw_r;

   // Next-state and register-index sequencing.
   always_comb begin
      state_nxt_s = state_r;
      k_nxt_s     = k_r;
      case (state_r)
         S_IDLE, S_DONE: begin
            if (accept_s) begin
               state_nxt_s = (cnt_clamp_s == CW'(0)) ? S_DONE : S_A_SET;
               k_nxt_s     = CW'(0);
            end else begin
               state_nxt_s = S_IDLE;
            end
         end
         S_A_SET: state_nxt_s = S_A_STB;
         S_A_STB: state_nxt_s = (tmr_r == TW'(0)) ? S_A_HLD : S_A_STB;
         S_A_HLD: state_nxt_s = (tmr_r == TW'(0)) ? S_A_GAP : S_A_HLD;
         S_A_GAP: state_nxt_s = (tmr_r == TW'(0)) ? S_D_SET : S_A_GAP;
         S_D_SET: state_nxt_s = S_D_STB;
         S_D_STB: state_nxt_s = (tmr_r == TW'(0)) ? S_D_HLD : S_D_STB;
         S_D_HLD: state_nxt_s = (tmr_r == TW'(0)) ? S_D_GAP : S_D_HLD;
         S_D_GAP: begin
            if (tmr_r != TW'(0)) begin
               state_nxt_s = S_D_GAP;
            end else if ((k_r + CW'(1)) < cnt_r) begin
               state_nxt_s = S_A_SET;
               k_nxt_s     = k_r + CW'(1);
            end else begin
               state_nxt_s = S_DONE;
            end
         end
         default: state_nxt_s = S_IDLE;
      endcase
   end

   // On accept the address comes straight from the request, since it is not latched yet.
   assign addr_nxt_s  = (accept_s ? base_addr : base_r) + DATA_W'(k_nxt_s);
   assign wbyte_nxt_s = wdat_r[k_nxt_s*DATA_W +: DATA_W];

   // Pin values for the state being entered, so the registered pins line up with the state.
   always_comb begin
      cs_n_nxt_s = 1'b1;
      ad_n_nxt_s = 1'b1;
      wr_n_nxt_s = 1'b1;
      rd_n_nxt_s = 1'b1;
      oe_nxt_s   = 1'b0;
      out_nxt_s  = '0;
      case (state_nxt_s)
         S_A_SET, S_A_STB, S_A_HLD: begin
            cs_n_nxt_s = 1'b0;
            ad_n_nxt_s = 1'b0;
            wr_n_nxt_s = (state_nxt_s == S_A_STB) ? 1'b0 : 1'b1;
            oe_nxt_s   = 1'b1;
            out_nxt_s  = addr_nxt_s;
         end
         S_D_SET, S_D_STB, S_D_HLD: begin
            cs_n_nxt_s = 1'b0;
            wr_n_nxt_s = ((state_nxt_s == S_D_STB) && !rw_r) ? 1'b0 : 1'b1;
            rd_n_nxt_s = ((state_nxt_s == S_D_STB) && rw_r) ? 1'b0 : 1'b1;
            oe_nxt_s   = !rw_r;
            out_nxt_s  = rw_r ? {DATA_W{1'b0}} : wbyte_nxt_s;
         end
         default: begin
            cs_n_nxt_s = 1'b1;
         end
      endcase
   end

   // FSM state, phase timer, request latches and registered outputs.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_r <= S_IDLE;
         tmr_r   <= '0;
         k_r     <= '0;
         cnt_r   <= '0;
         rw_r    <= 1'b0;
         base_r  <= '0;
         wdat_r  <= '0;
         cs_n_r  <= 1'b1;
         ad_n_r  <= 1'b1;
         wr_n_r  <= 1'b1;
         rd_n_r  <= 1'b1;
         oe_r    <= 1'b0;
         out_r   <= '0;
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         state_r <= state_nxt_s;
         tmr_r   <= ((state_nxt_s != state_r) || (tmr_r == TW'(0))) ? dur_m1(state_nxt_s)
                                                                    : tmr_r - TW'(1);
         k_r     <= k_nxt_s;
         if (accept_s) begin
            cnt_r  <= cnt_clamp_s;
            rw_r   <= rw;
            base_r <= base_addr;
            wdat_r <= wr_data;
         end
         cs_n_r <= cs_n_nxt_s;
         ad_n_r <= ad_n_nxt_s;
         wr_n_r <= wr_n_nxt_s;
         rd_n_r <= rd_n_nxt_s;
         oe_r   <= oe_nxt_s;
         out_r  <= out_nxt_s;
         busy_r <= (state_nxt_s != S_IDLE) && (state_nxt_s != S_DONE);
         done_r <= (state_nxt_s == S_DONE);
      end
   end

   // Read capture on the last strobe cycle; bytes not read keep their value.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         rd_data <= '0;
      end else if (capture_s) begin
         rd_data[k_r*DATA_W +: DATA_W] <= bus.bus_in;
      end else begin
         rd_data <= rd_data;
      end
   end

`ifdef RTC_BCD_CHECK_EN
   // Flags a byte holding any nibble above 9.
   function automatic logic bcd_bad(input logic [DATA_W-1:0] b);
      logic bad;
      bad = 1'b0;
      for (int i = 0; i < DATA_W / 4; i++) begin
         bad = bad | (b[i*4 +: 4] > 4'd9);
      end
      return bad;
   endfunction

   // Per-register BCD flags: cleared by a new read burst, updated at each capture.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         bcd_err <= '0;
      end else if (accept_s && rw) begin
         bcd_err <= '0;
      end else if (capture_s) begin
         bcd_err[k_r] <= bcd_bad(bus.bus_in);
      end else begin
         bcd_err <= bcd_err;
      end
   end
`else
   assign bcd_err = '0;
`endif

   assign bus.cs_n    = cs_n_r;
   assign bus.ad_n    = ad_n_r;
   assign bus.wr_n    = wr_n_r;
   assign bus.rd_n    = rd_n_r;
   assign bus.bus_oe  = oe_r;
   assign bus.bus_out = out_r;
   assign busy        = busy_r;
   assign done        = done_r;

endmodule

// File: tb/tb_rtc_bus_burst_ctrl.sv
// Self-checking bench for rtc_bus_burst_ctrl: directed and random bursts against a
// cycle-position reference model of the bus protocol.
module tb_rtc_bus_burst_ctrl;
   localparam int DATA_W = 8;
   localparam int NREG   = 9;
   localparam int T_STB  = 4;
   localparam int T_HLD  = 2;
   localparam int T_GAP  = 2;
   localparam int CW     = $clog2(NREG + 1);
   localparam int PH     = 1 + T_STB + T_HLD + T_GAP;
   localparam int RC     = 2 * PH;

   logic                   clk = 1'b0;
   logic                   reset;
   logic                   start;
   logic                   rw;
   logic [DATA_W-1:0]      base_addr;
   logic [CW-1:0]          count;
   logic [NREG*DATA_W-1:0] wr_data;
   logic [NREG*DATA_W-1:0] rd_data;
   logic                   busy;
   logic                   done;
   logic [NREG-1:0]        bcd_err;

   rtc_bus_burst_ctrl_if #(.DATA_W(DATA_W)) bus_if ();

   rtc_bus_burst_ctrl #(
      .DATA_W(DATA_W), .NREG(NREG), .T_STB(T_STB), .T_HLD(T_HLD), .T_GAP(T_GAP)
   ) dut (
      .clk(clk), .reset(reset), .start(start), .rw(rw), .base_addr(base_addr),
      .count(count), .wr_data(wr_data), .rd_data(rd_data), .busy(busy),
      .done(done), .bcd_err(bcd_err), .bus(bus_if.master)
   );

   always #5 clk = ~clk;

   int                n_pass  = 0;
   int                n_total = 0;
   logic [DATA_W-1:0] rd_src   [NREG];
   logic [DATA_W-1:0] rd_model [NREG];
   logic [NREG-1:0]   bcd_model;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      n_total++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
   endtask

   function automatic logic [4:0] pins();
      return {bus_if.cs_n, bus_if.ad_n, bus_if.wr_n, bus_if.rd_n, bus_if.bus_oe};
   endfunction

   // Expected {cs_n, ad_n, wr_n, rd_n, bus_oe} at position p within one register transfer.
   function automatic logic [4:0] exp_pins(input int p, input logic rd);
      logic a_on, d_on, a_stb, d_stb;
      int   q;
      q     = p - PH;
      a_on  = (p < 1 + T_STB + T_HLD);
      d_on  = (q >= 0) && (q < 1 + T_STB + T_HLD);
      a_stb = (p >= 1) && (p <= T_STB);
      d_stb = (q >= 1) && (q <= T_STB);
      return {!(a_on || d_on), !a_on, !(a_stb || (d_stb && !rd)), !(d_stb && rd),
              a_on || (d_on && !rd)};
   endfunction

   function automatic logic [NREG*DATA_W-1:0] packed_model();
      logic [NREG*DATA_W-1:0] v;
      for (int k = 0; k < NREG; k++) v[k*DATA_W +: DATA_W] = rd_model[k];
      return v;
   endfunction

   task automatic set_req(input logic r, input logic [DATA_W-1:0] b, input int c,
                          input logic [NREG*DATA_W-1:0] wd);
      rw        = r;
      base_addr = b;
      count     = CW'(c);
      wr_data   = wd;
      start     = 1'b1;
   endtask

   // Runs one burst whose request is already on the inputs; returns at the DONE-cycle midpoint.
   task automatic do_burst(input logic r, input logic [DATA_W-1:0] b, input int c_in,
                           input logic [NREG*DATA_W-1:0] wd, input bit inj);
      int                n;
      logic [4:0]        ep;
      logic [DATA_W-1:0] ea;
      n = (c_in > NREG) ? NREG : c_in;
      @(posedge clk);
`ifdef RTC_BCD_CHECK_EN
      if (r) bcd_model = '0;
`endif
      for (int c = 1; c <= n * RC; c++) begin
         int p, k;
         p = (c - 1) % RC;
         k = (c - 1) / RC;
         @(negedge clk);
         start = (inj && c == 5);
         if (inj && c == 5) begin
            rw        = ~r;
            base_addr = ~b;
            count     = CW'(1);
         end
         ep = exp_pins(p, r);
         chk("pins", pins(), ep);
         ea = b + DATA_W'(k);
         if (ep[0]) chk("bus_out", bus_if.bus_out, (p < PH) ? ea : wd[k*DATA_W +: DATA_W]);
         chk("busy_done", {busy, done}, 2'b10);
         bus_if.bus_in = (r && p == PH + T_STB) ? rd_src[k] : ~rd_src[k];
      end
      @(negedge clk);
      start = 1'b0;
      chk("done_cycle", {busy, done, pins()}, {2'b01, 5'b11110});
      if (r) begin
         for (int k = 0; k < n; k++) begin
            rd_model[k] = rd_src[k];
`ifdef RTC_BCD_CHECK_EN
            bcd_model[k] = (rd_src[k][7:4] > 4'd9) || (rd_src[k][3:0] > 4'd9);
`endif
         end
      end
      chk("rd_data", rd_data, packed_model());
      chk("bcd_err", bcd_err, bcd_model);
   endtask

   initial begin
      logic [NREG*DATA_W-1:0] wd;
      logic                   r;
      logic [DATA_W-1:0]      b;
      int                     c;

      reset = 1'b0; start = 1'b0; rw = 1'b0; base_addr = '0; count = '0; wr_data = '0;
      bus_if.bus_in = '0;
      bcd_model = '0;
      for (int k = 0; k < NREG; k++) begin
         rd_model[k] = '0;
         rd_src[k]   = '0;
      end
      repeat (3) @(negedge clk);
      reset = 1'b1;
      repeat (10) @(negedge clk);
      chk("reset_pins", {busy, done, pins()}, {2'b00, 5'b11110});
      chk("reset_bus_out", bus_if.bus_out, 8'h00);
      chk("reset_rd_data", rd_data, '0);
      chk("reset_bcd", bcd_err, '0);

      // Directed write of three registers starting at 0x21.
      wd = '0;
      wd[23:0] = 24'h123045;
      set_req(1'b0, 8'h21, 3, wd);
      do_burst(1'b0, 8'h21, 3, wd, 1'b0);

      // Directed read wrapping at 0xFF, with an ignored start mid-burst,
      // then a read chained from the DONE cycle.
      @(negedge clk);
      rd_src[0] = 8'h59;
      rd_src[1] = 8'h07;
      set_req(1'b1, 8'hFF, 2, '0);
      do_burst(1'b1, 8'hFF, 2, '0, 1'b1);
      chk("rd_wrap_bytes", rd_data[15:0], 16'h0759);
      rd_src[0] = 8'h5A;
      rd_src[1] = 8'h23;
      set_req(1'b1, 8'h10, 2, '0);
      do_burst(1'b1, 8'h10, 2, '0, 1'b0);
`ifdef RTC_BCD_CHECK_EN
      chk("bcd_dir", bcd_err[1:0], 2'b01);
`else
      chk("bcd_dir", bcd_err[1:0], 2'b00);
`endif

      // Zero-length write: done the cycle after start, busy never rises.
      @(negedge clk);
      set_req(1'b0, 8'h33, 0, '0);
      do_burst(1'b0, 8'h33, 0, '0, 1'b0);

      // Random bursts, including counts above NREG.
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         r  = 1'($urandom_range(0, 1));
         b  = DATA_W'($urandom);
         c  = $urandom_range(0, 11);
         wd = {$urandom, $urandom, $urandom};
         for (int k = 0; k < NREG; k++) rd_src[k] = DATA_W'($urandom);
         set_req(r, b, c, wd);
         do_burst(r, b, c, wd, 1'b0);
      end

      // Reset during the data strobe of a write.
      @(negedge clk);
      wd = {$urandom, $urandom, $urandom};
      set_req(1'b0, 8'h40, 2, wd);
      @(posedge clk);
      @(negedge clk);
      start = 1'b0;
      repeat (PH + 1) @(negedge clk);
      chk("pre_rst_dstb", pins(), exp_pins(PH + 1, 1'b0));
      #2 reset = 1'b0;
      #1 chk("rst_async", {busy, pins()}, {1'b0, 5'b11110});
      for (int k = 0; k < NREG; k++) rd_model[k] = '0;
      bcd_model = '0;
      repeat (3) begin
         @(negedge clk);
         chk("rst_no_done", {busy, done}, 2'b00);
      end
      reset = 1'b1;
      repeat (3) begin
         @(negedge clk);
         chk("post_rst_idle", {busy, done, pins()}, {2'b00, 5'b11110});
      end
      chk("post_rst_rd", rd_data, packed_model());

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end
endmodule
